// File: rtl/store_merge_unit.sv
// Store unit for a word-only data memory: SW writes directly, SH/SB do read-merge-write.
// Latency: SW done at T+1, SH/SB done at T+3, error pulse at T+1; accepts only in IDLE.
module store_merge_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [1:0]        st_sel,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    output logic              st_done,
    output logic              st_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [31:0]       mem_wdata
);

    localparam logic [1:0] SEL_SW = 2'b00;
    localparam logic [1:0] SEL_SH = 2'b01;
    localparam logic [1:0] SEL_SB = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_MERGE = 3'd2,
        S_WRITE = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr_q;
    logic [31:0]       r_data_q;
    logic [1:0]        r_sel_q;
    logic [31:0]       r_merged_q;
    logic [31:0]       w_merged;
    logic              w_accept;
    logic              w_bad;

    assign w_accept = st_valid && (r_state == S_IDLE);

    // Checking the live inputs at the accept edge is equivalent to checking
    // the values being latched, and lets SW reach WRITE one cycle later.
    assign w_bad = (st_sel == 2'b11) ||
                   ((st_sel == SEL_SW) && (st_addr[1:0] != 2'b00)) ||
                   ((st_sel == SEL_SH) && st_addr[0]);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_bad)                 w_next = S_ERR;
                    else if (st_sel == SEL_SW) w_next = S_WRITE;
                    else                       w_next = S_READ;
                end
            end
            S_READ:  w_next = S_MERGE;
            S_MERGE: w_next = S_WRITE;
            S_WRITE: w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_merged = mem_rdata;
        if (r_sel_q == SEL_SH) begin
            if (r_addr_q[1]) w_merged[31:16] = r_data_q[15:0];
            else             w_merged[15:0]  = r_data_q[15:0];
        end else if (r_sel_q == SEL_SB) begin
            w_merged[{r_addr_q[1:0], 3'b000} +: 8] = r_data_q[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_addr_q   <= '0;
            r_data_q   <= '0;
            r_sel_q    <= '0;
            r_merged_q <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr_q <= st_addr;
                r_data_q <= st_data;
                r_sel_q  <= st_sel;
            end
            // Read data is only sampled here, and always through a register.
            if (r_state == S_MERGE) r_merged_q <= w_merged;
        end
    end

    always_comb begin
        st_ready  = (r_state == S_IDLE);
        mem_re    = (r_state == S_READ);
        mem_we    = (r_state == S_WRITE);
        st_done   = (r_state == S_WRITE);
        st_err    = (r_state == S_ERR);
        mem_addr  = '0;
        mem_wdata = '0;
        if (r_state != S_IDLE) mem_addr = {r_addr_q[ADDR_W-1:2], 2'b00};
        if (r_state == S_WRITE) mem_wdata = (r_sel_q == SEL_SW) ? r_data_q : r_merged_q;
    end

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit with a small word memory behind it.
module tb_store_merge_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [1:0]  st_sel;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_done;
    logic        st_err;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_we;
    logic [31:0] mem_wdata;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:15];
    logic        pre_en  = 1'b0;
    logic [3:0]  pre_idx = 4'd0;
    logic [31:0] pre_val = 32'h0;

    store_merge_unit #(.ADDR_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_sel    (st_sel),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_done   (st_done),
        .st_err    (st_err),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata)
    );

    always #5 clk = ~clk;

    // Word memory: read data appears the cycle after mem_re.
    always @(posedge clk) begin
        if (pre_en)      mem[pre_idx] <= pre_val;
        else if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;
        if (mem_re)      mem_rdata <= mem[mem_addr[5:2]];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] val);
        pre_en = 1'b1; pre_idx = idx; pre_val = val;
        step();
        pre_en = 1'b0;
    endtask

    task automatic drive_req(input logic [1:0] sel, input logic [31:0] addr, input logic [31:0] data);
        st_valid = 1'b1; st_sel = sel; st_addr = addr; st_data = data;
    endtask

    task automatic test_reset();
        reset = 1'b0; st_valid = 1'b0; st_sel = 2'b00; st_addr = 32'h0; st_data = 32'h0;
        step(); step();
        checks++; if (st_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", st_ready); end
        checks++;
        if ({st_done, st_err, mem_re, mem_we} !== 4'b0000) begin
            failures++; $display("FAIL reset_strobes got=%b exp=0000", {st_done, st_err, mem_re, mem_we});
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            failures++; $display("FAIL reset_bus addr=%h wdata=%h exp=0/0", mem_addr, mem_wdata);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_sw();
        drive_req(2'b00, 32'h0000_0010, 32'hDEAD_BEEF);
        step();
        st_valid = 1'b0;
        checks++;
        if ({mem_we, st_done, mem_re, st_ready} !== 4'b1100) begin
            failures++; $display("FAIL sw_strobes we/done/re/rdy got=%b exp=1100", {mem_we, st_done, mem_re, st_ready});
        end
        checks++; if (mem_addr !== 32'h10) begin failures++; $display("FAIL sw_addr got=%h exp=00000010", mem_addr); end
        checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL sw_wdata got=%h exp=deadbeef", mem_wdata); end
        step();
        checks++;
        if ({st_ready, mem_we, mem_re} !== 3'b100) begin
            failures++; $display("FAIL sw_idle rdy/we/re got=%b exp=100", {st_ready, mem_we, mem_re});
        end
        checks++; if (mem[4] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL sw_mem got=%h exp=deadbeef", mem[4]); end
    endtask

    task automatic rmw(input string name, input logic [1:0] sel, input logic [31:0] addr,
                       input logic [31:0] data, input logic [31:0] exp_addr, input logic [31:0] exp_word);
        drive_req(sel, addr, data);
        step();
        st_valid = 1'b0;
        checks++;
        if ({mem_re, mem_we, st_ready} !== 3'b100 || mem_addr !== exp_addr) begin
            failures++; $display("FAIL %s_read re/we/rdy=%b addr=%h exp=100 addr=%h", name, {mem_re, mem_we, st_ready}, mem_addr, exp_addr);
        end
        step();
        checks++;
        if ({mem_re, mem_we, st_done, st_ready} !== 4'b0000 || mem_wdata !== 32'h0) begin
            failures++; $display("FAIL %s_merge strobes=%b wdata=%h exp=0000 wdata=0", name, {mem_re, mem_we, st_done, st_ready}, mem_wdata);
        end
        step();
        checks++;
        if ({mem_we, st_done, mem_re} !== 3'b110 || mem_addr !== exp_addr || mem_wdata !== exp_word) begin
            failures++; $display("FAIL %s_write we/done/re=%b addr=%h wdata=%h exp=110 addr=%h wdata=%h",
                                 name, {mem_we, st_done, mem_re}, mem_addr, mem_wdata, exp_addr, exp_word);
        end
        step();
        checks++;
        if (st_ready !== 1'b1 || mem[exp_addr[5:2]] !== exp_word) begin
            failures++; $display("FAIL %s_done rdy=%b mem=%h exp=1 mem=%h", name, st_ready, mem[exp_addr[5:2]], exp_word);
        end
    endtask

    task automatic test_sb();
        preload(4'd8, 32'h1122_3344);
        rmw("sb_lane3", 2'b10, 32'h0000_0023, 32'h0000_00AB, 32'h20, 32'hAB22_3344);
    endtask

    task automatic test_sh();
        preload(4'd1, 32'h1122_3344);
        rmw("sh_hi", 2'b01, 32'h0000_0006, 32'h0000_CAFE, 32'h04, 32'hCAFE_3344);
        preload(4'd1, 32'h1122_3344);
        rmw("sh_lo", 2'b01, 32'h0000_0004, 32'h0000_CAFE, 32'h04, 32'h1122_CAFE);
    endtask

    task automatic test_errors();
        logic [1:0]  sels  [3] = '{2'b00, 2'b01, 2'b11};
        logic [31:0] addrs [3] = '{32'h2, 32'h1, 32'h8};
        for (int i = 0; i < 3; i++) begin
            drive_req(sels[i], addrs[i], 32'h5555_AAAA);
            step();
            st_valid = 1'b0;
            checks++;
            if ({st_err, mem_re, mem_we, st_done, st_ready} !== 5'b10000) begin
                failures++; $display("FAIL err%0d_pulse err/re/we/done/rdy got=%b exp=10000", i, {st_err, mem_re, mem_we, st_done, st_ready});
            end
            step();
            checks++;
            if ({st_err, mem_re, mem_we, st_ready} !== 4'b0001) begin
                failures++; $display("FAIL err%0d_after err/re/we/rdy got=%b exp=0001", i, {st_err, mem_re, mem_we, st_ready});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w [4] = '{32'h0000_0011, 32'h0000_2211, 32'h0033_2211, 32'h4433_2211};
        logic [7:0]  dat   [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        preload(4'd0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            drive_req(2'b10, k, {24'h0, dat[k]});
            step();
            checks++;
            if ({st_ready, mem_re} !== 2'b01) begin failures++; $display("FAIL b2b%0d_read rdy/re got=%b exp=01", k, {st_ready, mem_re}); end
            step();
            checks++; if (st_ready !== 1'b0) begin failures++; $display("FAIL b2b%0d_merge rdy got=%b exp=0", k, st_ready); end
            step();
            checks++;
            if ({st_ready, mem_we} !== 2'b01 || mem_wdata !== exp_w[k]) begin
                failures++; $display("FAIL b2b%0d_write rdy/we=%b wdata=%h exp=01 wdata=%h", k, {st_ready, mem_we}, mem_wdata, exp_w[k]);
            end
            step();
            checks++; if (st_ready !== 1'b1) begin failures++; $display("FAIL b2b%0d_idle rdy got=%b exp=1", k, st_ready); end
        end
        st_valid = 1'b0;
        checks++; if (mem[0] !== 32'h4433_2211) begin failures++; $display("FAIL b2b_final got=%h exp=44332211", mem[0]); end
    endtask

    task automatic test_abort();
        int we_seen = 0;
        preload(4'd2, 32'hA5A5_A5A5);
        drive_req(2'b10, 32'h0000_0009, 32'h0000_0077);
        step();
        st_valid = 1'b0;
        step();
        reset = 1'b0;
        step();
        checks++;
        if ({st_ready, mem_we, st_done, mem_re} !== 4'b1000 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            failures++; $display("FAIL abort_reset rdy/we/done/re=%b addr=%h wdata=%h exp=1000 0 0",
                                 {st_ready, mem_we, st_done, mem_re}, mem_addr, mem_wdata);
        end
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (mem_we !== 1'b0 || st_ready !== 1'b1) we_seen++;
        end
        checks++; if (we_seen != 0) begin failures++; $display("FAIL abort_quiet bad_cycles got=%0d exp=0", we_seen); end
        checks++; if (mem[2] !== 32'hA5A5_A5A5) begin failures++; $display("FAIL abort_mem got=%h exp=a5a5a5a5", mem[2]); end
    endtask

    initial begin
        test_reset();
        test_sw();
        test_sb();
        test_sh();
        test_errors();
        test_back_to_back();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
